// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch / program-counter stage feeding execute
module fetch_unit #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            stall,
  input  logic            halt,
  input  logic            jump_flag,
  input  logic [7:0]      jump_offset,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  output logic            done,
  output logic [15:0]     retire_count
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            done_q, done_d;
  logic [15:0]     retire_q, retire_d;
  logic [PC_W-1:0] offset_ext;
  logic            live;

  assign offset_ext = {{(PC_W-8){jump_offset[7]}}, jump_offset};
  // an instruction is acted on only when it is real and the stage is not frozen
  assign live = (state_q == RUN) && instr_valid_q && !stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      retire_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
      retire_q      <= retire_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;
    retire_d      = retire_q;
    if (live && retire_q != 16'hFFFF) retire_d = retire_q + 16'd1;
    if (!stall) begin
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_d       = PRIME;
            fetch_pc_d    = start_pc;
            done_d        = 1'b0;
            retire_d      = '0;
            instr_valid_d = 1'b0;
          end
        end
        PRIME: begin
          state_d       = RUN;
          instr_valid_d = 1'b1;
          instr_pc_d    = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + PC_W'(1);
        end
        RUN: begin
          if (live && halt) begin
            state_d       = HALTED;
            done_d        = 1'b1;
            instr_valid_d = 1'b0;
          end else if (live && jump_flag) begin
            // the sequential fetch issued this cycle becomes the single bubble
            fetch_pc_d    = instr_pc_q + offset_ext;
            instr_valid_d = 1'b0;
          end else begin
            instr_valid_d = 1'b1;
            instr_pc_d    = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_en      = ((state_q == PRIME) || (state_q == RUN)) && !stall;
    imem_addr    = fetch_pc_q;
    instr_valid  = instr_valid_q;
    instr_pc     = instr_pc_q;
    done         = done_q;
    retire_count = retire_q;
  end

endmodule
